// File: rtl/dec38_seq_if.sv
// Handshake and output bundle for the dec38_seq registered 3-to-8 decoder / scan sequencer.
interface dec38_seq_if;
  logic       en;
  logic       in_valid;
  logic [2:0] in_code;
  logic       mode;
  logic       in_ready;
  logic [7:0] y;
  logic       y_valid;
  logic [2:0] code_out;

  modport master (
    output en, in_valid, in_code, mode,
    input  in_ready, y, y_valid, code_out
  );

  modport slave (
    input  en, in_valid, in_code, mode,
    output in_ready, y, y_valid, code_out
  );
endinterface

// File: rtl/dec38_seq.sv
// Registered 3-to-8 decoder with load/hold and rotating scan modes.
// Scan mode, SCAN state and dwell counter exist only when DEC38_SEQ_SCAN_EN is defined.
module dec38_seq #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  dec38_seq_if.slave bus
);

`ifdef DEC38_SEQ_SCAN_EN
  typedef enum logic [1:0] {StIdle, StHold, StScan} state_e;

  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(HOLD_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {StIdle, StHold} state_e;

  // Scan is not built: mode and the dwell setting are deliberately ignored.
  localparam int unsigned unused_hold_cycles = HOLD_CYCLES;
  logic unused_mode;
  assign unused_mode = bus.mode;
`endif

  state_e     state_q, state_d;
  logic [7:0] y_q, y_d;
  logic [2:0] code_q, code_d;
  logic       accept;

  assign bus.in_ready = bus.en;
  assign accept       = bus.in_valid & bus.en;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    code_d  = code_q;
`ifdef DEC38_SEQ_SCAN_EN
    cnt_d   = cnt_q;
`endif
    if (!bus.en) begin
      state_d = StIdle;
      y_d     = 8'h00;
      code_d  = 3'd0;
`ifdef DEC38_SEQ_SCAN_EN
      cnt_d   = '0;
`endif
    end else if (accept) begin
      // An accept always wins over a scan step due in the same cycle.
      y_d     = 8'h01 << bus.in_code;
      code_d  = bus.in_code;
      state_d = StHold;
`ifdef DEC38_SEQ_SCAN_EN
      cnt_d   = '0;
      if (bus.mode) state_d = StScan;
`endif
    end
`ifdef DEC38_SEQ_SCAN_EN
    else if (state_q == StScan) begin
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        code_d = code_q + 3'd1;
        y_d    = {y_q[6:0], y_q[7]};
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      y_q     <= 8'h00;
      code_q  <= 3'd0;
`ifdef DEC38_SEQ_SCAN_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      code_q  <= code_d;
`ifdef DEC38_SEQ_SCAN_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.y        = y_q;
  assign bus.code_out = code_q;
  assign bus.y_valid  = (state_q != StIdle);

endmodule

// File: tb/tb_dec38_seq.sv
// Self-checking bench for dec38_seq: directed test-plan steps plus random traffic
// compared against a positional model (start code + elapsed cycles / dwell).
module tb_dec38_seq;
  localparam int unsigned Hold = 3;
`ifdef DEC38_SEQ_SCAN_EN
  localparam bit ScanBuilt = 1'b1;
`else
  localparam bit ScanBuilt = 1'b0;
`endif

  logic clk;
  logic rst_n;
  dec38_seq_if bus ();

  dec38_seq #(.HOLD_CYCLES(Hold)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: after an accept, the shown position is start + elapsed/Hold (mod 8) in scan,
  // or simply start in hold.
  bit  m_valid = 1'b0;
  bit  m_scan  = 1'b0;
  int  m_start = 0;
  longint m_acc = 0;
  longint cyc   = 0;

  function automatic logic [2:0] exp_code();
    if (!m_valid) return 3'd0;
    if (m_scan) return 3'((m_start + int'((cyc - m_acc) / Hold)) % 8);
    return 3'(m_start);
  endfunction

  function automatic logic [7:0] exp_y();
    logic [7:0] one;
    one = 8'h01;
    if (!m_valid) return 8'h00;
    return one << exp_code();
  endfunction

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk8({tag, ".y"}, bus.y, exp_y());
    chk8({tag, ".y_valid"}, {7'd0, bus.y_valid}, {7'd0, m_valid});
    chk8({tag, ".code_out"}, {5'd0, bus.code_out}, {5'd0, exp_code()});
  endtask

  // Drive one cycle of inputs, check in_ready before the edge, outputs 1 time unit after.
  task automatic step(input bit en, input bit vld, input logic [2:0] code, input bit mode,
                      input string tag);
    bus.en       = en;
    bus.in_valid = vld;
    bus.in_code  = code;
    bus.mode     = mode;
    #1;
    chk8({tag, ".in_ready"}, {7'd0, bus.in_ready}, {7'd0, en});
    @(posedge clk);
    cyc++;
    if (!en) begin
      m_valid = 1'b0;
      m_scan  = 1'b0;
    end else if (vld) begin
      m_valid = 1'b1;
      m_scan  = ScanBuilt && mode;
      m_start = int'(code);
      m_acc   = cyc;
    end
    #1;
    check_out(tag);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 1'b0, tag);
  endtask

  // 8-3 encoder used to loop y back to a code.
  function automatic logic [3:0] enc83(input logic [7:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

  initial begin
    bus.en = 1'b0; bus.in_valid = 1'b0; bus.in_code = 3'd0; bus.mode = 1'b0;
    rst_n = 1'b0;
    #1;
    check_out("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3, "post_reset_idle");

    // Load sweep with encoder loop-back.
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b1, 3'(c), 1'b0, "load_sweep");
      chk8("load_loopback", {4'd0, enc83(bus.y)}, {4'd0, 1'b1, 3'(c)});
    end
    idle(4, "load_hold");

    // Scan wrap from 6: positions 6,7,0,1 each for Hold cycles (static 6 without scan).
    step(1'b1, 1'b1, 3'd6, 1'b1, "scan_start");
    idle(10, "scan_wrap");

    // Accept on the cycle a step is due; elapsed since accept is 11 -> due in Hold-(11%Hold).
    idle(int'(Hold - 1 - ((cyc - m_acc) % Hold)), "scan_pre");
    step(1'b1, 1'b1, 3'd2, 1'b0, "override");
    idle(8, "override_hold");

    // Enable drop while holding 0x10, with an offer in the same cycle.
    step(1'b1, 1'b1, 3'd4, 1'b0, "hold10");
    step(1'b0, 1'b1, 3'd1, 1'b0, "en_drop");
    idle(5, "en_back");

    // Mode=1 accept of 5; without scan this stays 0x20 for 100 cycles.
    step(1'b1, 1'b1, 3'd5, 1'b1, "mode1_c5");
    idle(100, "mode1_hold");

    // Asynchronous reset mid-scan (mid-hold in the scan-less build).
    step(1'b1, 1'b1, 3'd3, 1'b1, "pre_reset");
    idle(2, "pre_reset_run");
    #3;
    rst_n = 1'b0;
    m_valid = 1'b0;
    m_scan  = 1'b0;
    #1;
    check_out("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(6, "after_reset");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 8) != 0, ($urandom % 4) == 0, 3'($urandom % 8), ($urandom % 2) == 1,
           "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dec38_seq.md
# dec38_seq

Registered 3-to-8 decoder with a load/scan sequencer: turns a 3-bit code into a one-hot 8-bit line vector, which is the inverse of the team's 8-3 priority encoder. In load mode it latches and holds one decoded line. In scan mode it walks the active line around all eight positions at a programmable dwell rate, for driving LED or digit-select banks. Sits between control logic producing codes and one-hot consumers. Its `y` can be looped back into the 8-3 encoder for self-check.

## Interface
- `HOLD_CYCLES`, default 4: scan dwell in clock cycles per position; legal range 1..65535.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: block enable. Low forces outputs to zero, like the encoder `en`.
- `in_valid`  in  1: `in_code` / `mode` are offered this cycle.
- `in_code`  in  3: code to decode, or scan start position.
- `mode`  in  1: 0 = load/hold, 1 = scan.
- `in_ready`  out  1: block accepts an offer this cycle.
- `y`  out  8: one-hot decoded lines; all-zero when not valid.
- `y_valid`  out  1: `y` holds a decoded value (counterpart of encoder `t`).
- `code_out`  out  3: index of the active bit of `y`; 0 when `y_valid`=0.

## Operation
- **States.**
  - IDLE: `y`=0, `y_valid`=0.
  - HOLD: one bit of `y` set, static.
  - SCAN: one bit of `y` set, rotating.
- `in_ready` = `en` in every state, combinational.
- **Accept.** An offer is accepted when `in_valid` && `in_ready`.
- **Accept with `mode`=0**, from any state:
  - next cycle `y` = 1 << `in_code`, `code_out` = `in_code`, `y_valid`=1;
  - state becomes HOLD.
- **Accept with `mode`=1**, from any state:
  - next cycle `y` = 1 << `in_code` and state becomes SCAN;
  - dwell counter clears to 0.
- **HOLD.** Output is held indefinitely until a new accept or `en`=0. A new accept overwrites the output with no gap cycle.
- **SCAN.**
  - The dwell counter increments every cycle.
  - When the counter equals `HOLD_CYCLES`-1 it clears, and `code_out` increments mod 8: 7 wraps to 0, `y` rotates left, bit 7 goes to bit 0.
  - An accept in the same cycle as a step wins; the step is discarded.
- **`en`=0.**
  - Next edge: state IDLE, `y`=0, `y_valid`=0, `code_out`=0, dwell counter=0.
  - `in_ready`=0, so offers are ignored.
  - `en` rising returns the block to IDLE behaviour with no output until an accept.
- **Invariant.** `y` is always either all-zero with `y_valid`=0, or has exactly one bit set equal to 1 << `code_out` with `y_valid`=1. This must hold every cycle, including just after reset.
- **Dwell counter width:** $clog2(`HOLD_CYCLES`), minimum 1 bit.

## Timing
- Reset (`rst_n` low, asynchronous, immediate): state IDLE, `y`=8'h00, `y_valid`=0, `code_out`=3'd0, dwell counter 0.
- Reset deassertion is synchronised by the system; the block's first active edge is the first rising edge with `rst_n` high.
- Reset asserted mid-scan or mid-hold aborts immediately to the reset values.
- **Latency:** accept at edge N gives the decoded `y` visible after edge N (one cycle, registered outputs).
- **Scan period:** each position is shown for exactly `HOLD_CYCLES` cycles, so a full rotation takes 8×`HOLD_CYCLES` cycles. With `HOLD_CYCLES`=1, `y` changes every cycle.
- `en`=0 and an accept in the same cycle: `en` wins; the block goes to IDLE.
- All outputs except `in_ready` are registered, with no combinational path from inputs to `y`.

## Configuration
- **`DEC38_SEQ_SCAN_EN` defined:** scan mode, SCAN state and dwell counter are present, as described above.
- **`DEC38_SEQ_SCAN_EN` undefined:**
  - the dwell counter and SCAN state are not built;
  - `mode` is ignored, and every accept behaves as `mode`=0 (HOLD);
  - `HOLD_CYCLES` has no effect.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle during SCAN → `y`=00, `y_valid`=0, `code_out`=0 immediately, before the next edge; no activity after release until an accept.
- **Load sweep:** `en`=1, `mode`=0, `in_code`=0..7 on consecutive cycles → `y` = 01,02,04,…,80 one cycle later each, `y_valid`=1; feeding `y` into the 8-3 encoder returns `in_code` with `t`=1.
- **Scan wrap:** `HOLD_CYCLES`=3, accept `mode`=1, `in_code`=6 → `y`=40 for 3 cycles, then 80 for 3, then 01, then 02; `code_out` 6,7,0,1.
- **Accept overrides step:** during SCAN, accept `mode`=0, `in_code`=2 on the cycle the step is due → next cycle `y`=04, state HOLD, no further rotation.
- **Enable drop:** `en`=0 for one cycle while holding `y`=10, with `in_valid`=1 the same cycle → `in_ready`=0, next cycle `y`=00, `y_valid`=0; after `en`=1 the output stays 00 until the next accept.
- **Build without `DEC38_SEQ_SCAN_EN`:** accept `mode`=1, `in_code`=5 → `y`=20, held unchanged for 100 cycles.
